// File: rtl/misc_v_pkg.sv
// Shared definitions for the memory-access pipeline stage: default widths,
// wait-counter width and the stage FSM encoding.
package misc_v_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_RD_W   = 4;

    // Wide enough for the largest legal timeout (255).
    localparam int WAIT_CNT_W     = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait counter for an outstanding memory access. The expired flag
// is combinational: it fires in the cycle whose increment would bring the
// count up to LIMIT, so the owner can leave on the next edge.
module mem_wait_timer #(
    parameter int W     = 8,
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    logic [W-1:0] count_q, count_d;

    // Next count: clear wins, otherwise increment while enabled, never wrap.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = enable_i && !clear_i && (count_q == W'(LIMIT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage. ALU results pass straight through with one cycle of
// latency; loads and stores are captured, held on the data-memory port until
// mem_ready (or the wait timer expires), and upstream is stalled meanwhile.
module mem_access_stage
    import misc_v_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int RD_W    = DEFAULT_RD_W,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic              i_reg_write,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic [DATA_W-1:0] i_store_data,
    input  logic [RD_W-1:0]   i_rd,
    output logic              o_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              o_valid,
    output logic              o_reg_write,
    output logic              o_mem_to_reg,
    output logic [DATA_W-1:0] o_alu_result,
    output logic [DATA_W-1:0] o_load_data,
    output logic [RD_W-1:0]   o_rd,
    output logic              o_mem_err
);

    mem_state_e        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [RD_W-1:0]   cap_rd_q, cap_rd_d;
    logic              cap_rw_q, cap_rw_d;
    logic              o_valid_q, o_valid_d;
    logic              o_reg_write_q, o_reg_write_d;
    logic              o_mem_to_reg_q, o_mem_to_reg_d;
    logic              o_mem_err_q, o_mem_err_d;
    logic [DATA_W-1:0] o_alu_result_q, o_alu_result_d;
    logic [DATA_W-1:0] o_load_data_q, o_load_data_d;
    logic [RD_W-1:0]   o_rd_q, o_rd_d;

    logic tmr_clear, tmr_en, tmr_expired;

    mem_wait_timer #(
        .W     (WAIT_CNT_W),
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (tmr_clear),
        .enable_i  (tmr_en),
        .expired_o (tmr_expired)
    );

    // Next-state and registered-output logic; the address register doubles
    // as the captured ALU result for the writeback of a memory op.
    always_comb begin
        state_d        = state_q;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        cap_rd_d       = cap_rd_q;
        cap_rw_d       = cap_rw_q;
        o_valid_d      = 1'b0;
        o_reg_write_d  = 1'b0;
        o_mem_to_reg_d = o_mem_to_reg_q;
        o_mem_err_d    = 1'b0;
        o_alu_result_d = o_alu_result_q;
        o_load_data_d  = o_load_data_q;
        o_rd_d         = o_rd_q;
        tmr_clear      = 1'b0;
        tmr_en         = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    if (i_mem_read || i_mem_write) begin
                        // Write wins when both flags are set.
                        state_d     = ACCESS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = i_mem_write;
                        mem_addr_d  = i_alu_result;
                        mem_wdata_d = i_store_data;
                        cap_rd_d    = i_rd;
                        cap_rw_d    = i_reg_write;
                        tmr_clear   = 1'b1;
                    end else begin
                        o_valid_d      = 1'b1;
                        o_reg_write_d  = i_reg_write;
                        o_mem_to_reg_d = 1'b0;
                        o_alu_result_d = i_alu_result;
                        o_rd_d         = i_rd;
                    end
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    state_d        = IDLE;
                    mem_req_d      = 1'b0;
                    mem_we_d       = 1'b0;
                    o_valid_d      = 1'b1;
                    o_rd_d         = cap_rd_q;
                    o_alu_result_d = mem_addr_q;
                    o_reg_write_d  = cap_rw_q;
                    if (mem_we_q) begin
                        o_mem_to_reg_d = 1'b0;
                    end else begin
                        o_mem_to_reg_d = 1'b1;
                        o_load_data_d  = mem_rdata;
                    end
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_expired) begin
                        // Give up: retire the instruction flagged, no writeback.
                        state_d        = IDLE;
                        mem_req_d      = 1'b0;
                        mem_we_d       = 1'b0;
                        o_valid_d      = 1'b1;
                        o_mem_err_d    = 1'b1;
                        o_reg_write_d  = 1'b0;
                        o_mem_to_reg_d = 1'b0;
                        o_load_data_d  = '0;
                        o_rd_d         = cap_rd_q;
                        o_alu_result_d = mem_addr_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            cap_rd_q       <= '0;
            cap_rw_q       <= 1'b0;
            o_valid_q      <= 1'b0;
            o_reg_write_q  <= 1'b0;
            o_mem_to_reg_q <= 1'b0;
            o_mem_err_q    <= 1'b0;
            o_alu_result_q <= '0;
            o_load_data_q  <= '0;
            o_rd_q         <= '0;
        end else begin
            state_q        <= state_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            cap_rd_q       <= cap_rd_d;
            cap_rw_q       <= cap_rw_d;
            o_valid_q      <= o_valid_d;
            o_reg_write_q  <= o_reg_write_d;
            o_mem_to_reg_q <= o_mem_to_reg_d;
            o_mem_err_q    <= o_mem_err_d;
            o_alu_result_q <= o_alu_result_d;
            o_load_data_q  <= o_load_data_d;
            o_rd_q         <= o_rd_d;
        end
    end

    assign o_stall      = (state_q == ACCESS);
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign o_valid      = o_valid_q;
    assign o_reg_write  = o_reg_write_q;
    assign o_mem_to_reg = o_mem_to_reg_q;
    assign o_mem_err    = o_mem_err_q;
    assign o_alu_result = o_alu_result_q;
    assign o_load_data  = o_load_data_q;
    assign o_rd         = o_rd_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: a table of ALU-op vectors plus directed
// sequences for loads, stores, timeout and reset during an access.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid, i_mem_read, i_mem_write, i_reg_write;
    logic [15:0] i_alu_result, i_store_data;
    logic [3:0]  i_rd;
    logic        o_stall, mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic        o_valid, o_reg_write, o_mem_to_reg;
    logic [15:0] o_alu_result, o_load_data;
    logic [3:0]  o_rd;
    logic        o_mem_err;

    int checks   = 0;
    int failures = 0;

    mem_access_stage #(.DATA_W(16), .RD_W(4), .TIMEOUT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_valid      (i_valid),
        .i_mem_read   (i_mem_read),
        .i_mem_write  (i_mem_write),
        .i_reg_write  (i_reg_write),
        .i_alu_result (i_alu_result),
        .i_store_data (i_store_data),
        .i_rd         (i_rd),
        .o_stall      (o_stall),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .o_valid      (o_valid),
        .o_reg_write  (o_reg_write),
        .o_mem_to_reg (o_mem_to_reg),
        .o_alu_result (o_alu_result),
        .o_load_data  (o_load_data),
        .o_rd         (o_rd),
        .o_mem_err    (o_mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        rw;
        logic [15:0] alu;
        logic [3:0]  rd;
        logic        e_v;
        logic        e_rw;
        logic [15:0] e_alu;
        logic [3:0]  e_rd;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rd_f, input logic wr_f, input logic rw,
                         input logic [15:0] alu, input logic [15:0] sd, input logic [3:0] rd);
        i_valid      = v;
        i_mem_read   = rd_f;
        i_mem_write  = wr_f;
        i_reg_write  = rw;
        i_alu_result = alu;
        i_store_data = sd;
        i_rd         = rd;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 16'h1234, 4'd3,  1'b1, 1'b1, 16'h1234, 4'd3};
        vecs[1] = '{1'b0, 1'b1, 16'hFFFF, 4'd7,  1'b0, 1'b0, 16'h1234, 4'd3};
        vecs[2] = '{1'b1, 1'b0, 16'hABCD, 4'hF,  1'b1, 1'b0, 16'hABCD, 4'hF};
        vecs[3] = '{1'b1, 1'b1, 16'h0000, 4'd0,  1'b1, 1'b1, 16'h0000, 4'd0};
        vecs[4] = '{1'b1, 1'b1, 16'hFFFF, 4'hA,  1'b1, 1'b1, 16'hFFFF, 4'hA};
        vecs[5] = '{1'b0, 1'b0, 16'h5A5A, 4'd1,  1'b0, 1'b0, 16'hFFFF, 4'hA};

        reset = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = 16'h0;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h7777, 16'h1111, 4'd9);
        step();
        step();
        // Reset state (inputs were active, reset must override)
        chk("rst_o_valid", 32'(o_valid), 0);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_stall", 32'(o_stall), 0);
        chk("rst_alu", 32'(o_alu_result), 0);
        chk("rst_load", 32'(o_load_data), 0);
        chk("rst_rd", 32'(o_rd), 0);
        chk("rst_rw", 32'(o_reg_write), 0);
        chk("rst_m2r", 32'(o_mem_to_reg), 0);
        chk("rst_err", 32'(o_mem_err), 0);
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'd0);
        step();

        // ALU pass-through table
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].v, 1'b0, 1'b0, vecs[i].rw, vecs[i].alu, 16'h0, vecs[i].rd);
            step();
            chk($sformatf("vec%0d_valid", i), 32'(o_valid), 32'(vecs[i].e_v));
            chk($sformatf("vec%0d_rw", i), 32'(o_reg_write), 32'(vecs[i].e_rw));
            chk($sformatf("vec%0d_alu", i), 32'(o_alu_result), 32'(vecs[i].e_alu));
            chk($sformatf("vec%0d_rd", i), 32'(o_rd), 32'(vecs[i].e_rd));
            chk($sformatf("vec%0d_m2r", i), 32'(o_mem_to_reg), 0);
            chk($sformatf("vec%0d_req", i), 32'(mem_req), 0);
        end

        // mem_ready while idle is ignored
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'd0);
        mem_ready = 1'b1;
        mem_rdata = 16'hDEAD;
        step();
        chk("idle_rdy_valid", 32'(o_valid), 0);
        chk("idle_rdy_req", 32'(mem_req), 0);
        chk("idle_rdy_load", 32'(o_load_data), 0);
        mem_ready = 1'b0;

        // Load, ready in third access cycle
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0040, 16'h0, 4'd5);
        step();
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("ld_stall_c%0d", c), 32'(o_stall), 1);
            chk($sformatf("ld_req_c%0d", c), 32'(mem_req), 1);
            chk($sformatf("ld_we_c%0d", c), 32'(mem_we), 0);
            chk($sformatf("ld_addr_c%0d", c), 32'(mem_addr), 32'h0040);
            chk($sformatf("ld_valid_c%0d", c), 32'(o_valid), 0);
            if (c == 3) begin
                mem_ready = 1'b1;
                mem_rdata = 16'hBEEF;
            end
            step();
        end
        mem_ready = 1'b0;
        mem_rdata = 16'h0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'd0);
        chk("ld_done_valid", 32'(o_valid), 1);
        chk("ld_done_load", 32'(o_load_data), 32'hBEEF);
        chk("ld_done_m2r", 32'(o_mem_to_reg), 1);
        chk("ld_done_rd", 32'(o_rd), 5);
        chk("ld_done_alu", 32'(o_alu_result), 32'h0040);
        chk("ld_done_rw", 32'(o_reg_write), 1);
        chk("ld_done_req", 32'(mem_req), 0);
        chk("ld_done_stall", 32'(o_stall), 0);
        step();
        chk("ld_after_valid", 32'(o_valid), 0);
        chk("ld_after_load", 32'(o_load_data), 32'hBEEF);

        // Store, ready in first access cycle (two-cycle latency)
        drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h00FF, 4'd4);
        step();
        chk("st_req", 32'(mem_req), 1);
        chk("st_we", 32'(mem_we), 1);
        chk("st_addr", 32'(mem_addr), 32'h0010);
        chk("st_wdata", 32'(mem_wdata), 32'h00FF);
        chk("st_valid0", 32'(o_valid), 0);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'd0);
        chk("st_done_valid", 32'(o_valid), 1);
        chk("st_done_m2r", 32'(o_mem_to_reg), 0);
        chk("st_done_load", 32'(o_load_data), 32'hBEEF);
        chk("st_done_rw", 32'(o_reg_write), 0);
        chk("st_done_req", 32'(mem_req), 0);

        // Read and write both set: behaves as a store
        drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h0020, 16'h1357, 4'd6);
        step();
        chk("rw_we", 32'(mem_we), 1);
        chk("rw_wdata", 32'(mem_wdata), 32'h1357);
        mem_ready = 1'b1;
        mem_rdata = 16'h9999;
        step();
        mem_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'd0);
        chk("rw_done_m2r", 32'(o_mem_to_reg), 0);
        chk("rw_done_load", 32'(o_load_data), 32'hBEEF);
        chk("rw_done_rw", 32'(o_reg_write), 1);

        // Timeout: load with no mem_ready, TIMEOUT=4
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0080, 16'h0, 4'd6);
        step();
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("to_stall_c%0d", c), 32'(o_stall), 1);
            chk($sformatf("to_err_c%0d", c), 32'(o_mem_err), 0);
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'd0);
        chk("to_stall_exit", 32'(o_stall), 0);
        chk("to_req_exit", 32'(mem_req), 0);
        chk("to_valid", 32'(o_valid), 1);
        chk("to_err", 32'(o_mem_err), 1);
        chk("to_rw", 32'(o_reg_write), 0);
        chk("to_load", 32'(o_load_data), 0);
        step();
        chk("to_err_pulse", 32'(o_mem_err), 0);
        chk("to_valid_after", 32'(o_valid), 0);

        // mem_ready in the cycle the timer would expire: normal completion
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0090, 16'h0, 4'd8);
        step();
        step();
        step();
        step();
        chk("race_stall_c4", 32'(o_stall), 1);
        mem_ready = 1'b1;
        mem_rdata = 16'h2468;
        step();
        mem_ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'd0);
        chk("race_valid", 32'(o_valid), 1);
        chk("race_err", 32'(o_mem_err), 0);
        chk("race_load", 32'(o_load_data), 32'h2468);
        chk("race_rd", 32'(o_rd), 8);

        // Reset in second access cycle, late mem_ready ignored
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h00A0, 16'h0, 4'd2);
        step();
        step();
        chk("rsta_stall_c2", 32'(o_stall), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'd0);
        chk("rsta_req", 32'(mem_req), 0);
        chk("rsta_stall", 32'(o_stall), 0);
        chk("rsta_valid", 32'(o_valid), 0);
        mem_ready = 1'b1;
        mem_rdata = 16'h4321;
        step();
        mem_ready = 1'b0;
        chk("rsta_late_valid", 32'(o_valid), 0);
        chk("rsta_late_req", 32'(mem_req), 0);
        chk("rsta_late_load", 32'(o_load_data), 0);

        // Back-to-back: load then ALU op held under stall
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0022, 16'h0, 4'd2);
        step();
        chk("b2b_stall", 32'(o_stall), 1);
        mem_ready = 1'b1;
        mem_rdata = 16'hCAFE;
        step();
        mem_ready = 1'b0;
        chk("b2b_ld_valid", 32'(o_valid), 1);
        chk("b2b_ld_load", 32'(o_load_data), 32'hCAFE);
        chk("b2b_ld_rd", 32'(o_rd), 2);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h5555, 16'h0, 4'd9);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'd0);
        chk("b2b_alu_valid", 32'(o_valid), 1);
        chk("b2b_alu_res", 32'(o_alu_result), 32'h5555);
        chk("b2b_alu_rd", 32'(o_rd), 9);
        chk("b2b_alu_m2r", 32'(o_mem_to_reg), 0);
        chk("b2b_alu_rw", 32'(o_reg_write), 1);
        chk("b2b_alu_load", 32'(o_load_data), 32'hCAFE);
        chk("b2b_alu_req", 32'(mem_req), 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter DATA_W, 16, datapath and address width.
REQ-002 Parameter RD_W, 4, destination-register index width.
REQ-003 Parameter TIMEOUT, 255, max cycles waiting for mem_ready; legal range 1..255.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 i_valid, i_mem_read, i_mem_write, i_reg_write  in  1 each  EX/MEM instruction valid and controls.
REQ-007 i_alu_result  in  DATA_W  address for memory ops, result otherwise; i_store_data  in  DATA_W  store data; i_rd  in  RD_W  destination.
REQ-008 o_stall  out  1  upstream holds all i_* while high.
REQ-009 mem_req, mem_we  out  1 each  data-memory request and write enable; mem_addr, mem_wdata  out  DATA_W.
REQ-010 mem_ready  in  1  memory completion; mem_rdata  in  DATA_W  read data, valid with mem_ready.
REQ-011 o_valid, o_reg_write, o_mem_to_reg  out  1 each  to MEM/WB; o_alu_result, o_load_data  out  DATA_W; o_rd  out  RD_W.
REQ-012 o_mem_err  out  1  one-cycle pulse, memory access timed out.

Function
REQ-013 FSM states IDLE and ACCESS only; all outputs except o_stall registered.
REQ-014 IDLE, i_valid=1, neither mem flag: next cycle o_valid=1, o_reg_write=i_reg_write, o_mem_to_reg=0, o_alu_result=i_alu_result, o_rd=i_rd; latency 1.
REQ-015 IDLE, i_valid=0: next cycle o_valid=0, o_reg_write=0, other data outputs hold.
REQ-016 IDLE, i_valid=1 with i_mem_read or i_mem_write: instruction captured internally, next state ACCESS, o_valid=0 next cycle.
REQ-017 i_mem_read and i_mem_write both high: treated as write.
REQ-018 ACCESS: mem_req=1, mem_we=captured write flag, mem_addr=captured i_alu_result, mem_wdata=captured i_store_data, all stable until exit.
REQ-019 o_stall = (state==ACCESS); combinational; upstream must not change i_* while high.
REQ-020 ACCESS, mem_ready=1 in cycle k: next cycle (k+1) state IDLE, mem_req=0, o_valid=1, o_rd, o_alu_result, o_reg_write from capture; read: o_load_data=mem_rdata sampled in k, o_mem_to_reg=1; write: o_mem_to_reg=0, o_load_data held.
REQ-021 mem_ready=1 in first ACCESS cycle is legal: minimum memory-op latency 2 cycles from acceptance to o_valid.
REQ-022 mem_ready while state IDLE ignored.
REQ-023 Wait counter clears on ACCESS entry, increments each ACCESS cycle without mem_ready; saturates, never wraps.
REQ-024 Counter reaching TIMEOUT without mem_ready: next cycle IDLE, mem_req=0, o_valid=1, o_mem_err=1, o_reg_write=0, o_load_data=0.
REQ-025 mem_ready in the same cycle the counter reaches TIMEOUT: normal completion wins, o_mem_err=0.
REQ-026 Instruction in IDLE the cycle after completion accepted normally; no extra bubble.

Reset
REQ-027 reset high at rising edge: state IDLE, counter 0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, o_valid=0, o_reg_write=0, o_mem_to_reg=0, o_mem_err=0, o_alu_result=0, o_load_data=0, o_rd=0.
REQ-028 Reset during ACCESS abandons the access; mem_req low in first post-reset cycle; late mem_ready ignored.
REQ-029 reset overrides all other inputs in the same cycle.

Structure
REQ-030 Shared package misc_v_pkg holds DATA_W, RD_W defaults and the mem-stage state enum (IDLE, ACCESS).
REQ-031 Sub-module mem_wait_timer (clear, enable, saturating count, expired flag) implements REQ-023/024.

Verification
REQ-032 ALU op alu=0x1234, rd=3, reg_write=1 -> next cycle o_valid=1, o_alu_result=0x1234, o_rd=3, o_mem_to_reg=0, no mem_req.
REQ-033 Load addr=0x0040, mem_ready after 3 ACCESS cycles with rdata=0xBEEF -> o_stall high 3 cycles, mem_addr=0x0040 stable, then o_valid=1, o_load_data=0xBEEF, o_mem_to_reg=1.
REQ-034 Store addr=0x0010, data=0x00FF, mem_ready in first ACCESS cycle -> mem_we=1, mem_wdata=0x00FF, o_valid one cycle later, o_mem_to_reg=0.
REQ-035 TIMEOUT=4, load, mem_ready never -> exit after 4 ACCESS cycles, o_mem_err pulse 1 cycle, o_reg_write=0, o_load_data=0.
REQ-036 Reset asserted second ACCESS cycle, mem_ready next cycle -> state IDLE, mem_req=0, o_valid stays 0.
REQ-037 Back-to-back load then ALU op held under stall -> ALU op o_valid the cycle after load o_valid, values intact.
